// File: rtl/seq_divider_if.sv
// Divide request/response bundle between the execute stage and seq_divider.
interface seq_divider_if;
   logic         valid;
   logic         wordEn;
   logic [63:0]  a;
   logic [63:0]  b;
   logic         done;
   logic [127:0] c;

   // Execute stage side: issues operands, consumes the result.
   modport master (
      output valid, wordEn, a, b,
      input  done, c
   );

   // Divider side.
   modport slave (
      input  valid, wordEn, a, b,
      output done, c
   );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
// 64-bit mode runs 64 iterations; word mode runs 32 on a pre-shifted dividend
// and returns sign-extended 32-bit quotient/remainder.
module seq_divider (
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t       state_q, state_d;
   logic [63:0]  divisor_q, divisor_d;
   logic [63:0]  dividend_q, dividend_d;
   logic [63:0]  rem_q, rem_d;
   logic [63:0]  quot_q, quot_d;
   logic [6:0]   cnt_q, cnt_d;
   logic         word_q, word_d;
   logic         done_q, done_d;
   logic [127:0] c_q, c_d;

   // The partial remainder is always below the divisor, so 64 bits hold it;
   // only the trial value needs the 65th bit.
   logic [64:0]  trial;
   logic [63:0]  diff;
   logic         ge;
   logic [63:0]  rem_next;
   logic [63:0]  quot_next;

   // One restoring step: shift in the next dividend bit and try to subtract.
   always_comb begin
      trial     = {rem_q, dividend_q[63]};
      ge        = (trial >= {1'b0, divisor_q});
      diff      = trial[63:0] - divisor_q;
      rem_next  = ge ? diff : trial[63:0];
      quot_next = {quot_q[62:0], ge};
   end

   // Next-state and datapath control for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d    = state_q;
      divisor_d  = divisor_q;
      dividend_d = dividend_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      done_d     = 1'b0;
      c_d        = c_q;
      case (state_q)
         IDLE: begin
            if (bus.valid) begin
               divisor_d  = bus.wordEn ? {32'b0, bus.b[31:0]} : bus.b;
               // Word dividend sits in the top half so MSB-first shifting is shared.
               dividend_d = bus.wordEn ? {bus.a[31:0], 32'b0} : bus.a;
               word_d     = bus.wordEn;
               rem_d      = '0;
               quot_d     = '0;
               cnt_d      = bus.wordEn ? 7'd32 : 7'd64;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            rem_d      = rem_next;
            quot_d     = quot_next;
            dividend_d = {dividend_q[62:0], 1'b0};
            cnt_d      = cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
               state_d = DONE;
               done_d  = 1'b1;
               if (word_q) begin
                  c_d = {{32{rem_next[31]}}, rem_next[31:0],
                         {32{quot_next[31]}}, quot_next[31:0]};
               end else begin
                  c_d = {rem_next, quot_next};
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         divisor_q  <= '0;
         dividend_q <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         cnt_q      <= '0;
         word_q     <= 1'b0;
         done_q     <= 1'b0;
         c_q        <= '0;
      end else begin
         state_q    <= state_d;
         divisor_q  <= divisor_d;
         dividend_q <= dividend_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         done_q     <= done_d;
         c_q        <= c_d;
      end
   end

   assign bus.done = done_q;
   assign bus.c    = c_q;

endmodule
